ppa_gp_gen_stage: RTL and testbench
===================================

// Module: ppa_gp_gen_stage
// PURPOSE
//  Registered pre-processing stage of the parallel-prefix adder (PPA).
//  - Accepts operands A, B and carry-in over a valid/ready handshake.
//  - Produces per-bit generate, alive (propagate) and half-sum vectors.
//  - These feed the comb22 prefix tree directly downstream.
//  - A 2-entry skid buffer decouples the upstream from tree back-pressure without a combinational ready path.
// PARAMETERS
//  WIDTH  16  operand width in bits, >= 2
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      stage can accept a beat (registered)
//  a_in       in   WIDTH  operand A
//  b_in       in   WIDTH  operand B
//  cin        in   1      carry-in
//  out_valid  out  1      g/alive/hs beat valid
//  out_ready  in   1      prefix tree accepts beat
//  g_out      out  WIDTH  generate; bit 0 has cin folded in
//  alive_out  out  WIDTH  alive = a_i | b_i
//  hs_out     out  WIDTH  half-sum = a_i ^ b_i, for the sum post-stage
//  cin_out    out  1      registered cin, for sum bit 0
// BEHAVIOUR
//  Reset:
//  - Reset is asynchronous, active-low. Deasserting rst_n releases the stage into the empty state.
//  - Reset value of every output: out_valid=0, in_ready=1, g/alive/hs/cin_out=0.
//  - Reset clears both buffer entries. In-flight beats are discarded, not replayed.
//  Datapath (computed on capture, width WIDTH, no overflow):
//  - For i>=1: g_i = a_i & b_i.
//  - g_0 = (a_0 & b_0) | ((a_0 | b_0) & cin).
//  - alive_i = a_i | b_i.
//  - hs_i = a_i ^ b_i.
//  - cin_out = cin.
//  Storage: main register M (drives outputs) and skid register S.
//  States are {EMPTY, ONE (M valid), FULL (M and S valid)}:
//  - EMPTY: in_valid -> load M, go ONE.
//  - ONE:
//    - out_ready & !in_valid -> EMPTY.
//    - out_ready & in_valid -> reload M, stay ONE.
//    - !out_ready & in_valid -> load S, go FULL.
//  - FULL (in_ready=0, in_valid ignored): out_ready -> M<=S, go ONE.
//  Handshake:
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - in_ready = !S_valid, driven from a flop. No combinational path from out_ready to in_ready.
//  - out_valid = M_valid.
//  - Outputs are stable while out_valid & !out_ready.
//  - Order is strictly FIFO. No beat is dropped or duplicated.
//  - Latency is 1 cycle: a beat accepted at edge k is presented after edge k.
//  - Throughput is 1 beat/cycle when out_ready is held high.
//  Simultaneous in and out in ONE: both transfers occur in the same cycle.
// TESTING (WIDTH=8 unless stated)
//  1. Reset, then one beat a=0x0F b=0x01 cin=0 -> next cycle out_valid=1, g=0x01, alive=0x0F, hs=0x0E, cin_out=0.
//  2. a=0x00 b=0x01 cin=1 -> g=0x01 (carry-in fold), alive=0x01, hs=0x01, cin_out=1.
//  3. out_ready=0, push beats X,Y,Z back-to-back:
//     - X lands in M, Y lands in S.
//     - in_ready=0 from the cycle after Y is accepted, and Z stalls.
//     - Raise out_ready: X, Y, Z emerge in order, no gaps.
//  4. Stream of 100 random beats with out_ready=1 -> one output per cycle, matching the golden model, 1-cycle latency.
//  5. Assert rst_n=0 mid-stream in state FULL -> out_valid drops immediately, in_ready=1, and no stale beat appears after release.
//  6. WIDTH=32, a=0xFFFFFFFF b=0x00000001 cin=1 -> g=0x00000001, alive=0xFFFFFFFF, hs=0xFFFFFFFE, cin_out=1.

Source files
------------

// File: rtl/ppa_gp_gen_stage.sv
// Pre-processing stage of the parallel-prefix adder.
// Turns each operand beat into per-bit generate, alive and half-sum vectors
// for the prefix tree. A main register (M) drives the outputs. A skid
// register (S) absorbs one extra beat, so in_ready can come straight from
// a flop instead of depending combinationally on out_ready.
module ppa_gp_gen_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] alive_out,
  output logic [WIDTH-1:0] hs_out,
  output logic             cin_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] new_g;
  logic [WIDTH-1:0] new_alive;
  logic [WIDTH-1:0] new_hs;
  logic [WIDTH-1:0] s_g;
  logic [WIDTH-1:0] s_alive;
  logic [WIDTH-1:0] s_hs;
  logic             s_cin;

  // Per-bit generate/alive/half-sum of the incoming beat. Bit 0 folds in the
  // carry-in, so the prefix tree never needs a separate carry-in input.
  always_comb begin
    new_alive = a_in | b_in;
    new_hs    = a_in ^ b_in;
    new_g     = a_in & b_in;
    new_g[0]  = (a_in[0] & b_in[0]) | ((a_in[0] | b_in[0]) & cin);
  end

  // Skid-buffer FSM. This block also holds M (the output registers), S,
  // out_valid and in_ready. Both flags are written from the next state, so
  // they always stay in step with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      g_out     <= '0;
      alive_out <= '0;
      hs_out    <= '0;
      cin_out   <= 1'b0;
      s_g       <= '0;
      s_alive   <= '0;
      s_hs      <= '0;
      s_cin     <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_valid) begin
            g_out     <= new_g;
            alive_out <= new_alive;
            hs_out    <= new_hs;
            cin_out   <= cin;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (out_ready) begin
            if (in_valid) begin
              g_out     <= new_g;
              alive_out <= new_alive;
              hs_out    <= new_hs;
              cin_out   <= cin;
            end else begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
          end else if (in_valid) begin
            s_g      <= new_g;
            s_alive  <= new_alive;
            s_hs     <= new_hs;
            s_cin    <= cin;
            in_ready <= 1'b0;
            state    <= FULL;
          end
        end
        FULL: begin
          if (out_ready) begin
            g_out     <= s_g;
            alive_out <= s_alive;
            hs_out    <= s_hs;
            cin_out   <= s_cin;
            in_ready  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ppa_gp_gen_stage.sv
// Directed testbench for ppa_gp_gen_stage. It drives an 8-bit instance
// through reset, single beats, skid-buffer back-pressure, a random stream
// and a reset taken while the buffer is full. A 32-bit instance covers the
// wide-operand case.
module tb_ppa_gp_gen_stage;

  logic       clk;
  logic       rst_n;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] g_out;
  logic [7:0] alive_out;
  logic [7:0] hs_out;
  logic       cin_out;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] a_in32;
  logic [31:0] b_in32;
  logic        cin32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] g_out32;
  logic [31:0] alive_out32;
  logic [31:0] hs_out32;
  logic        cin_out32;

  int tests;
  int fails;

  ppa_gp_gen_stage #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .g_out     (g_out),
    .alive_out (alive_out),
    .hs_out    (hs_out),
    .cin_out   (cin_out)
  );

  ppa_gp_gen_stage #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid32),
    .in_ready  (in_ready32),
    .a_in      (a_in32),
    .b_in      (b_in32),
    .cin       (cin32),
    .out_valid (out_valid32),
    .out_ready (out_ready32),
    .g_out     (g_out32),
    .alive_out (alive_out32),
    .hs_out    (hs_out32),
    .cin_out   (cin_out32)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden model, written directly from the adder's bit equations.
  function automatic logic [24:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] g;
    g    = a & b;
    g[0] = (a[0] & b[0]) | ((a[0] | b[0]) & c);
    return {g, a | b, a ^ b, c};
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
    in_valid = v;
    a_in     = a;
    b_in     = b;
    cin      = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    out_ready   = 1'b1;
    in_valid32  = 1'b0;
    a_in32      = '0;
    b_in32      = '0;
    cin32       = 1'b0;
    out_ready32 = 1'b1;
    repeat (2) step();
    tests++;
    if ({out_valid, in_ready, g_out, alive_out, hs_out, cin_out} !== {1'b0, 1'b1, 25'h0}) begin
      fails++;
      $display("[TB] FAIL reset_state: got v=%b r=%b g=%h al=%h hs=%h c=%b, want v=0 r=1 all zero",
               out_valid, in_ready, g_out, alive_out, hs_out, cin_out);
    end
    #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_beat();
    applyStimulus(1'b1, 8'h0F, 8'h01, 1'b0);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tests++;
    if ({out_valid, g_out, alive_out, hs_out, cin_out} !== {1'b1, 8'h01, 8'h0F, 8'h0E, 1'b0}) begin
      fails++;
      $display("[TB] FAIL single_beat: got v=%b g=%h al=%h hs=%h c=%b, want v=1 g=01 al=0f hs=0e c=0",
               out_valid, g_out, alive_out, hs_out, cin_out);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL single_beat_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_cin_fold();
    applyStimulus(1'b1, 8'h00, 8'h01, 1'b1);
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tests++;
    if ({out_valid, g_out, alive_out, hs_out, cin_out} !== {1'b1, 8'h01, 8'h01, 8'h01, 1'b1}) begin
      fails++;
      $display("[TB] FAIL cin_fold: got v=%b g=%h al=%h hs=%h c=%b, want v=1 g=01 al=01 hs=01 c=1",
               out_valid, g_out, alive_out, hs_out, cin_out);
    end
    step();
  endtask

  task automatic test_back_to_back();
    // X = 0x33/0x11 c=0, Y = 0x80/0x80 c=1, Z = 0x05/0x0A c=1
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'h33, 8'h11, 1'b0);
    step();
    tests++;
    if ({out_valid, in_ready, g_out, alive_out, hs_out} !== {1'b1, 1'b1, 8'h11, 8'h33, 8'h22}) begin
      fails++;
      $display("[TB] FAIL b2b_x_in_m: got v=%b r=%b g=%h al=%h hs=%h, want v=1 r=1 g=11 al=33 hs=22",
               out_valid, in_ready, g_out, alive_out, hs_out);
    end
    applyStimulus(1'b1, 8'h80, 8'h80, 1'b1);
    step();
    tests++;
    if ({in_ready, g_out} !== {1'b0, 8'h11}) begin
      fails++;
      $display("[TB] FAIL b2b_full: got in_ready=%b g=%h, want in_ready=0 g=11", in_ready, g_out);
    end
    applyStimulus(1'b1, 8'h05, 8'h0A, 1'b1);
    step();
    tests++;
    if ({out_valid, in_ready, g_out, alive_out, hs_out, cin_out} !== {1'b1, 1'b0, 8'h11, 8'h33, 8'h22, 1'b0}) begin
      fails++;
      $display("[TB] FAIL b2b_stall: got v=%b r=%b g=%h al=%h hs=%h c=%b, want v=1 r=0 g=11 al=33 hs=22 c=0",
               out_valid, in_ready, g_out, alive_out, hs_out, cin_out);
    end
    out_ready = 1'b1;
    step();
    tests++;
    if ({out_valid, in_ready, g_out, alive_out, hs_out, cin_out} !== {1'b1, 1'b1, 8'h80, 8'h80, 8'h00, 1'b1}) begin
      fails++;
      $display("[TB] FAIL b2b_y_out: got v=%b r=%b g=%h al=%h hs=%h c=%b, want v=1 r=1 g=80 al=80 hs=00 c=1",
               out_valid, in_ready, g_out, alive_out, hs_out, cin_out);
    end
    step();
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    tests++;
    if ({out_valid, g_out, alive_out, hs_out, cin_out} !== {1'b1, 8'h01, 8'h0F, 8'h0F, 1'b1}) begin
      fails++;
      $display("[TB] FAIL b2b_z_out: got v=%b g=%h al=%h hs=%h c=%b, want v=1 g=01 al=0f hs=0f c=1",
               out_valid, g_out, alive_out, hs_out, cin_out);
    end
    step();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++;
      $display("[TB] FAIL b2b_drain: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [7:0]  a;
    logic [7:0]  b;
    logic        c;
    logic [24:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      applyStimulus(1'b1, a, b, c);
      exp = model8(a, b, c);
      step();
      tests++;
      if ({out_valid, in_ready, g_out, alive_out, hs_out, cin_out} !== {1'b1, 1'b1, exp}) begin
        fails++;
        $display("[TB] FAIL stream_%0d: got v=%b r=%b g=%h al=%h hs=%h c=%b, want v=1 r=1 g=%h al=%h hs=%h c=%b",
                 i, out_valid, in_ready, g_out, alive_out, hs_out, cin_out,
                 exp[24:17], exp[16:9], exp[8:1], exp[0]);
      end
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    step();
  endtask

  task automatic test_reset_in_full();
    out_ready = 1'b0;
    applyStimulus(1'b1, 8'hAA, 8'h55, 1'b0);
    step();
    applyStimulus(1'b1, 8'hC3, 8'h3C, 1'b1);
    step();
    tests++;
    if ({out_valid, in_ready} !== 2'b10) begin
      fails++;
      $display("[TB] FAIL full_before_reset: got v=%b r=%b, want v=1 r=0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, in_ready, g_out, cin_out} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      fails++;
      $display("[TB] FAIL async_reset: got v=%b r=%b g=%h c=%b, want v=0 r=1 g=00 c=0",
               out_valid, in_ready, g_out, cin_out);
    end
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({out_valid, in_ready} !== 2'b01) begin
        fails++;
        $display("[TB] FAIL no_stale_%0d: got v=%b r=%b, want v=0 r=1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_width32();
    in_valid32  = 1'b1;
    a_in32      = 32'hFFFFFFFF;
    b_in32      = 32'h00000001;
    cin32       = 1'b1;
    out_ready32 = 1'b1;
    step();
    in_valid32 = 1'b0;
    tests++;
    if ({out_valid32, g_out32, alive_out32, hs_out32, cin_out32} !==
        {1'b1, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1}) begin
      fails++;
      $display("[TB] FAIL width32: got v=%b g=%h al=%h hs=%h c=%b, want v=1 g=00000001 al=ffffffff hs=fffffffe c=1",
               out_valid32, g_out32, alive_out32, hs_out32, cin_out32);
    end
    step();
  endtask

  // Scenario sequence.
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_beat();
    test_cin_fold();
    test_back_to_back();
    test_stream();
    test_reset_in_full();
    test_width32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
